cache_line_arbiter: RTL

- Shares the single cacheline-wide physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches and the burst cacheline adaptor that drives the external burst memory port.
- Grants one requester at a time and latches its request for the whole transaction.
- Returns the response only to the granted cache.

---
 rtl/cache_line_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/cache_line_arbiter.sv
// Arbitrates the shared cacheline memory port between the icache and the dcache.
// The granted request is latched for the whole transaction. The response is routed only to the granted cache.
module cache_line_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic              d_req;
  logic              d_wins;

  assign d_req  = d_read | d_write;
  // On a tie D wins in fixed-priority mode, or in round-robin mode when I was served last.
  assign d_wins = d_req && (!i_read || (ARB_MODE != 0) || (last_grant_q == GRANT_I));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = d_address;
          wdata_d      = d_wdata;
          pmem_write_d = d_write;
          pmem_read_d  = ~d_write;
        end else if (i_read) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = i_address;
          wdata_d      = '0;
          pmem_read_d  = 1'b1;
          pmem_write_d = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d      = RELEASE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign busy         = (state_q != IDLE);

  assign i_resp  = (state_q == SERVE_I) && pmem_resp;
  assign d_resp  = (state_q == SERVE_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule
